// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, command bit positions and address helpers
// for the HD44780-style LCD panel responder.
`default_nettype none

package lcd_pkg;

   typedef enum logic [1:0] {
      S_READY    = 2'd0,
      S_CLEARING = 2'd1,
      S_BUSY     = 2'd2
   } state_t;

   // Highest set bit of a command byte selects the instruction.
   localparam int CMD_CLEAR_BIT   = 0;
   localparam int CMD_HOME_BIT    = 1;
   localparam int CMD_ENTRY_BIT   = 2;
   localparam int CMD_DISPLAY_BIT = 3;
   localparam int CMD_SHIFT_BIT   = 4;
   localparam int CMD_FUNC_BIT    = 5;
   localparam int CMD_CGRAM_BIT   = 6;
   localparam int CMD_DDRAM_BIT   = 7;

   localparam int ENTRY_ID_BIT = 1;
   localparam int DISP_D_BIT   = 2;
   localparam int DISP_C_BIT   = 1;
   localparam int DISP_B_BIT   = 0;
   localparam int SHIFT_SC_BIT = 3;
   localparam int SHIFT_RL_BIT = 2;

   localparam logic [7:0] BLANK_CHAR    = 8'h20;
   localparam logic [6:0] LINE1_BASE    = 7'h00;
   localparam logic [6:0] LINE2_BASE    = 7'h40;
   localparam logic [6:0] LINE_LAST_OFS = 7'h0F;

   // Address counter step; the two visible 16-char lines chain into each other.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      if (inc) begin
         if (ac == LINE1_BASE + LINE_LAST_OFS) return LINE2_BASE;
         if (ac == LINE2_BASE + LINE_LAST_OFS) return LINE1_BASE;
         return ac + 7'd1;
      end
      if (ac == LINE2_BASE) return LINE1_BASE + LINE_LAST_OFS;
      if (ac == LINE1_BASE) return LINE2_BASE + LINE_LAST_OFS;
      return ac - 7'd1;
   endfunction

   // Returns {valid, index[4:0]} of the visible DDRAM entry for an AC value.
   function automatic logic [5:0] ac_map(input logic [6:0] ac);
      if (ac[6:4] == LINE1_BASE[6:4]) return {1'b1, 1'b0, ac[3:0]};
      if (ac[6:4] == LINE2_BASE[6:4]) return {1'b1, 1'b1, ac[3:0]};
      return 6'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_busy_timer.sv
// lcd_busy_timer: loadable down-counter; done is high once the count reaches 1 or below.
`default_nettype none

module lcd_busy_timer #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign done = (count <= WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/lcd_panel_responder.sv
// lcd_panel_responder: behavioural HD44780-style 16x2 LCD controller model on the panel bus.
// Define LCD_RESP_READ_EN to enable busy-flag and data reads.
`default_nettype none

module lcd_panel_responder #(
   parameter int BUSY_SHORT_CYC = 2000,
   parameter int BUSY_LONG_CYC  = 76000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char,
   output logic       busy,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic [6:0] addr_counter,
   output logic       protocol_err,
   output logic [15:0] cmd_count
);

   import lcd_pkg::*;

   localparam int MAX_CYC = (BUSY_LONG_CYC > BUSY_SHORT_CYC) ? BUSY_LONG_CYC : BUSY_SHORT_CYC;
   localparam int TW      = $clog2(MAX_CYC + 1);

   state_t        state, next_state;
   logic          e_d1, strobe;
   logic [4:0]    clr_idx;
   logic [6:0]    ac;
   logic          id_inc, cg_mode;
   logic [7:0]    ddram [32];
   logic          tmr_load, tmr_done;
   logic [TW-1:0] tmr_val;
   logic          cmd_acc, dwr_acc, drd_acc, set_err;
   logic [5:0]    wr_map;

   assign strobe = e_d1 & ~lcd_e;
   assign busy   = (state != S_READY);
   assign wr_map = ac_map(ac);

   assign cmd_acc = strobe && state == S_READY && !lcd_rw && !lcd_rs;
   assign dwr_acc = strobe && state == S_READY && !lcd_rw &&  lcd_rs;
`ifdef LCD_RESP_READ_EN
   assign drd_acc = strobe && state == S_READY && lcd_rw && lcd_rs;
   // Busy-flag reads are legal everywhere; only writes and data reads collide with busy.
   assign set_err = strobe && state != S_READY && (!lcd_rw || lcd_rs);
`else
   assign drd_acc = 1'b0;
   assign set_err = strobe && (lcd_rw || state != S_READY);
`endif

   lcd_busy_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_READY;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      unique case (state)
         S_READY: begin
            if (cmd_acc && lcd_data_in == 8'h01) begin
               next_state = S_CLEARING;
            end else if (cmd_acc && lcd_data_in[7:1] == 7'd1) begin
               next_state = S_BUSY;
               tmr_load   = 1'b1;
               tmr_val    = TW'(BUSY_LONG_CYC);
            end else if (cmd_acc || dwr_acc || drd_acc) begin
               next_state = S_BUSY;
               tmr_load   = 1'b1;
               tmr_val    = TW'(BUSY_SHORT_CYC);
            end
         end
         S_CLEARING: begin
            if (clr_idx == 5'd31) begin
               next_state = S_BUSY;
               tmr_load   = 1'b1;
               tmr_val    = TW'(BUSY_LONG_CYC);
            end
         end
         S_BUSY: begin
            if (tmr_done) next_state = S_READY;
         end
         default: next_state = S_READY;
      endcase
   end

   // The entry-mode S flag and function-set bits have no visible effect and are not kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_d1         <= 1'b0;
         clr_idx      <= 5'd0;
         ac           <= LINE1_BASE;
         id_inc       <= 1'b1;
         cg_mode      <= 1'b0;
         display_on   <= 1'b0;
         cursor_on    <= 1'b0;
         blink_on     <= 1'b0;
         protocol_err <= 1'b0;
         cmd_count    <= 16'd0;
         for (int i = 0; i < 32; i++) ddram[i] <= BLANK_CHAR;
      end else begin
         e_d1 <= lcd_e;
         if (state == S_CLEARING) begin
            ddram[clr_idx] <= BLANK_CHAR;
            clr_idx        <= clr_idx + 5'd1;
         end
         if (cmd_acc) begin
            priority casez (lcd_data_in)
               8'b1???????: begin
                  ac      <= lcd_data_in[6:0];
                  cg_mode <= 1'b0;
               end
               8'b01??????: cg_mode <= 1'b1;
               8'b001?????: ;
               8'b0001????: begin
                  if (!lcd_data_in[SHIFT_SC_BIT]) ac <= ac_step(ac, lcd_data_in[SHIFT_RL_BIT]);
               end
               8'b00001???: begin
                  display_on <= lcd_data_in[DISP_D_BIT];
                  cursor_on  <= lcd_data_in[DISP_C_BIT];
                  blink_on   <= lcd_data_in[DISP_B_BIT];
               end
               8'b000001??: id_inc <= lcd_data_in[ENTRY_ID_BIT];
               8'b0000001?: ac <= LINE1_BASE;
               8'b00000001: begin
                  ac     <= LINE1_BASE;
                  id_inc <= 1'b1;
               end
               default: ;
            endcase
         end
         if (dwr_acc && !cg_mode) begin
            if (wr_map[5]) ddram[wr_map[4:0]] <= lcd_data_in;
            ac <= ac_step(ac, id_inc);
         end
         if (drd_acc) ac <= ac_step(ac, id_inc);
         if (set_err) protocol_err <= 1'b1;
         if ((cmd_acc || dwr_acc || drd_acc) && cmd_count != 16'hFFFF)
            cmd_count <= cmd_count + 16'd1;
      end
   end

`ifdef LCD_RESP_READ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lcd_data_oe  <= 1'b0;
         lcd_data_out <= 8'h00;
      end else begin
         lcd_data_oe <= lcd_e & lcd_rw;
         if (!(lcd_e && lcd_rw))      lcd_data_out <= 8'h00;
         else if (!lcd_rs)            lcd_data_out <= {busy, ac};
         else if (state != S_READY)   lcd_data_out <= 8'h00;
         else if (wr_map[5])          lcd_data_out <= ddram[wr_map[4:0]];
         else                         lcd_data_out <= BLANK_CHAR;
      end
   end
`else
   assign lcd_data_out = 8'h00;
   assign lcd_data_oe  = 1'b0;
`endif

   assign rd_char      = ddram[rd_idx];
   assign addr_counter = ac;

endmodule

`default_nettype wire

// File: doc/lcd_panel_responder.md
LCD_PANEL_RESPONDER -- requirements
Module: lcd_panel_responder

Interface
REQ-001 Parameter BUSY_SHORT_CYC, default 2000, meaning busy cycles after a normal command or data access (40 us at 50 MHz).
REQ-002 Parameter BUSY_LONG_CYC, default 76000, meaning busy cycles after Clear or Return Home (1.52 ms).
REQ-003 Port clk, input, 1, system clock (50 MHz).
REQ-004 Port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port lcd_rs, lcd_rw, lcd_e, input, 1 each, bus register select, read/write and enable from the LCD driver.
REQ-006 Port lcd_data_in, input, 8, write data bus.
REQ-007 Port lcd_data_out, output, 8, read data; port lcd_data_oe, output, 1, drive-enable for reads.
REQ-008 Port rd_idx, input, 5, and rd_char, output, 8, combinational peek into visible DDRAM (0-15 line 1, 16-31 line 2).
REQ-009 Port busy, display_on, cursor_on, blink_on, output, 1 each; port addr_counter, output, 7.
REQ-010 Port protocol_err, output, 1, sticky violation flag; port cmd_count, output, 16, saturating count of accepted strobes.

Function
REQ-011 Strobe is the lcd_e falling edge: e_d1 & ~lcd_e, with e_d1 registered on clk; rs, rw and data are sampled in that same cycle.
REQ-012 States: S_READY, S_CLEARING and S_BUSY; a strobe is accepted only in S_READY.
REQ-013 A write strobe (rw=0) arriving in S_CLEARING or S_BUSY shall be ignored and set protocol_err.
REQ-014 Commands (rs=0, rw=0) decode by highest set bit of data.
- 0x01 Clear: AC=0, I/D=1, then S_CLEARING.
- 0x02/03 Home: AC=0, long busy.
- 0x04-07 Entry mode: store I/D (bit1) and S (bit0; stored only).
- 0x08-0F Display: D, C, B to display_on, cursor_on, blink_on.
- 0x10-1F Shift: S/C=0 moves AC by R/L (bit2); S/C=1 is a no-op.
- 0x20-3F Function set: stored, no effect.
- 0x40-7F CGRAM address: sets cg_mode=1; following data writes are discarded.
- 0x80-FF DDRAM address: AC=data[6:0], cg_mode=0.
REQ-015 All commands except Clear and Home load BUSY_SHORT_CYC and enter S_BUSY.
REQ-016 S_CLEARING writes 0x20 to one DDRAM entry per clock, indices 0 to 31 (32 cycles), then loads BUSY_LONG_CYC and enters S_BUSY.
REQ-017 A data write (rs=1, rw=0) stores data at the mapped AC, then advances AC per I/D and applies short busy.
- AC 0x00-0x0F maps to index AC.
- AC 0x40-0x4F maps to index AC-0x30.
- Any other AC discards the data but still advances AC.
REQ-018 AC advance is mod 128, except increment 0x0F->0x40 and 0x4F->0x00, and decrement 0x40->0x0F and 0x00->0x4F.
REQ-019 Busy-flag read (rs=0, rw=1) is legal in every state and gives lcd_data_out={busy,AC} with lcd_data_oe=1 while lcd_e=1; it causes no busy and no AC change.
REQ-020 Data read (rs=1, rw=1) in S_READY gives lcd_data_out=DDRAM[map(AC)] (0x20 if unmapped); on the strobe, AC advances and short busy applies.
REQ-021 A data read while busy shall return 0x00 and set protocol_err.
REQ-022 busy=1 exactly in S_CLEARING and S_BUSY; S_BUSY counts down to 1 and then returns to S_READY.
REQ-023 cmd_count increments on each accepted non-busy-read strobe and saturates at 0xFFFF.

Reset
REQ-024 On reset_n low:
- State S_READY; AC=0; I/D=1.
- display_on, cursor_on, blink_on = 0; cg_mode=0.
- DDRAM all 0x20; busy=0; protocol_err=0; cmd_count=0.
- lcd_data_out=0x00; lcd_data_oe=0.
REQ-025 Reset asserted mid-clear or mid-busy aborts immediately to the reset values.

Configuration
REQ-026 With macro LCD_RESP_READ_EN defined, REQ-019 to REQ-021 apply.
REQ-027 Without LCD_RESP_READ_EN:
- lcd_data_out=0x00 and lcd_data_oe=0 constantly.
- rw=1 strobes are ignored and set protocol_err.

Structure
REQ-028 Shared package lcd_pkg holds the state enum, command bit positions, the 0x20 blank character, and the line base constants 0x00 and 0x40.
REQ-029 One sub-module, lcd_busy_timer, provides a loadable down-counter with a done output.

Verification
REQ-030 Init sequence 0x38, 0x0C, 0x01, 0x06, with waits of BUSY_LONG_CYC+40 cycles -> display_on=1, cursor_on=0, AC=0, protocol_err=0, all rd_char=0x20.
REQ-031 0x80, then data "A"(0x41) and "B"(0x42) -> rd_char[0]=0x41, rd_char[1]=0x42, AC=0x02.
REQ-032 0x8F, then two data writes 0x31 and 0x32 -> index 15=0x31, index 16=0x32, AC=0x41.
REQ-033 Clear followed by a write strobe 1000 cycles later -> write ignored, protocol_err=1, busy=1.
REQ-034 With LCD_RESP_READ_EN, busy read right after Clear -> lcd_data_out[7]=1; data read at AC=0x40 after writing 0x5A there -> 0x5A, and AC advances to 0x41.
REQ-035 reset_n pulsed low during S_CLEARING -> all reset values at the next clk edge.
